// File: rtl/bg_pixel_fifo.sv
// Background pixel FIFO/shifter between the tile fetcher and the LCD writer.
// Optional define PPU_BG_ENABLE_EN adds lcdc0, which blanks background shades when low.
module bg_pixel_fifo #(
    parameter int DEPTH      = 16,
    parameter int LINE_WIDTH = 160
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     line_start,
    input  logic                     mode3,
    input  logic                     flush,
    input  logic [2:0]               scx_fine,
    input  logic [7:0]               bgp,
    input  logic                     write_en,
    input  logic [7:0][12:0]         write_data,
`ifdef PPU_BG_ENABLE_EN
    input  logic                     lcdc0,
`endif
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     pixel_valid,
    output logic [7:0]               pixel_x,
    output logic [1:0]               pixel_shade,
    output logic                     line_done,
    output logic                     overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Only the 2-bit color index reaches the shade lookup, so only it is stored.
    logic [1:0]       mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [2:0]       discard_r;
    logic             done_r;
    logic [7:0]       pixel_x_r;
    logic             pixel_valid_r;
    logic [1:0]       pixel_shade_r;
    logic             line_done_r;
    logic             overflow_r;

    logic             clear_s;
    logic             push_ok_s;
    logic             drop_s;
    logic             pop_s;
    logic             emit_s;
    logic             last_s;
    logic [7:0]       col_next_s;
    logic [PTR_W-1:0] wr_base_s;
    logic [CNT_W-1:0] count_next_s;
    logic [1:0]       color_s;
    logic [1:0]       shade_s;
    logic             unused_s;

    assign unused_s = ^write_data;

    // Push/pop qualification; flush and line_start clear before an accompanying push lands.
    always_comb begin
        clear_s   = flush | line_start;
        push_ok_s = 1'b0;
        drop_s    = 1'b0;
        if (!write_en) begin
            push_ok_s = 1'b0;
        end else if (clear_s) begin
            push_ok_s = 1'b1;
        end else if (count_r <= CNT_W'(DEPTH - 8)) begin
            push_ok_s = 1'b1;
        end else begin
            drop_s = 1'b1;
        end
        pop_s  = mode3 & ~done_r & (count_r != '0) & ~clear_s;
        emit_s = pop_s & (discard_r == 3'd0);
    end

    // Column of the next emitted pixel: advances after each shown pixel, parks on the last one.
    always_comb begin
        if (pixel_valid_r && (pixel_x_r != 8'(LINE_WIDTH - 1))) begin
            col_next_s = pixel_x_r + 8'd1;
        end else begin
            col_next_s = pixel_x_r;
        end
        last_s = emit_s & (col_next_s == 8'(LINE_WIDTH - 1));
    end

    // Next occupancy and write base, folding in any same-cycle clear.
    always_comb begin
        if (clear_s) begin
            wr_base_s    = '0;
            count_next_s = '0;
        end else begin
            wr_base_s    = wr_ptr_r;
            count_next_s = count_r;
        end
        if (push_ok_s) begin
            count_next_s = count_next_s + CNT_W'(8);
        end else begin
            count_next_s = count_next_s;
        end
        if (pop_s) begin
            count_next_s = count_next_s - CNT_W'(1);
        end else begin
            count_next_s = count_next_s;
        end
    end

    // BGP lookup of the entry at the read pointer.
    always_comb begin
        color_s = mem_r[rd_ptr_r];
        case (color_s)
            2'd0:    shade_s = bgp[1:0];
            2'd1:    shade_s = bgp[3:2];
            2'd2:    shade_s = bgp[5:4];
            2'd3:    shade_s = bgp[7:6];
            default: shade_s = 2'b00;
        endcase
`ifdef PPU_BG_ENABLE_EN
        if (!lcdc0) begin
            shade_s = 2'b00;
        end else begin
            shade_s = shade_s;
        end
`endif
    end

    // Pixel storage: eight consecutive slots per accepted push.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            for (int i = 0; i < 8; i++) begin
                mem_r[wr_base_s + PTR_W'(i)] <= write_data[i][1:0];
            end
        end
    end

    // Pointers, occupancy, scroll discard and line progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r  <= '0;
            rd_ptr_r  <= '0;
            count_r   <= '0;
            discard_r <= 3'd0;
            done_r    <= 1'b0;
            pixel_x_r <= 8'd0;
        end else begin
            wr_ptr_r <= push_ok_s ? (wr_base_s + PTR_W'(8)) : wr_base_s;
            count_r  <= count_next_s;
            if (clear_s) begin
                rd_ptr_r <= '0;
            end else if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            if (line_start) begin
                discard_r <= scx_fine;
                done_r    <= 1'b0;
                pixel_x_r <= 8'd0;
            end else begin
                if (pop_s && (discard_r != 3'd0)) begin
                    discard_r <= discard_r - 3'd1;
                end
                if (last_s) begin
                    done_r <= 1'b1;
                end
                pixel_x_r <= col_next_s;
            end
        end
    end

    // Registered pixel outputs and status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pixel_valid_r <= 1'b0;
            pixel_shade_r <= 2'b00;
            line_done_r   <= 1'b0;
            overflow_r    <= 1'b0;
        end else begin
            pixel_valid_r <= emit_s;
            line_done_r   <= last_s;
            if (emit_s) begin
                pixel_shade_r <= shade_s;
            end
            if (line_start) begin
                overflow_r <= 1'b0;
            end else if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    assign empty       = (count_r == '0);
    assign count       = count_r;
    assign pixel_valid = pixel_valid_r;
    assign pixel_x     = pixel_x_r;
    assign pixel_shade = pixel_shade_r;
    assign line_done   = line_done_r;
    assign overflow    = overflow_r;

endmodule
